// File: rtl/npu_pkg.sv
// Shared types and defaults for the NPU matrix-unit front end.
// Holds the sequencer state encoding and counter width helper.
package npu_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_MATRIX_SIZE = 8;
    localparam int DEF_TIMEOUT     = 1024;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DRAIN  = 3'd5
    } drv_state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmu_stream_driver_if.sv
// Word streams of the matrix-unit front end: weights in,
// input vector in, results out.
interface mmu_stream_driver_if
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]   s_wt_data;
    logic                    s_wt_valid;
    logic                    s_wt_ready;
    logic [DATA_WIDTH-1:0]   s_in_data;
    logic                    s_in_valid;
    logic                    s_in_ready;
    logic [2*DATA_WIDTH-1:0] m_out_data;
    logic                    m_out_valid;
    logic                    m_out_ready;
    logic                    m_out_last;

    modport master (
        output s_wt_data, s_wt_valid, s_in_data, s_in_valid, m_out_ready,
        input  s_wt_ready, s_in_ready, m_out_data, m_out_valid, m_out_last
    );

    modport slave (
        input  s_wt_data, s_wt_valid, s_in_data, s_in_valid, m_out_ready,
        output s_wt_ready, s_in_ready, m_out_data, m_out_valid, m_out_last
    );
endinterface

// File: rtl/mmu_result_serializer.sv
// Captures the matrix-unit result vector and drains it one word
// per handshake, flagging the final word.
module mmu_result_serializer
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr_i,
    input  logic                                capture_i,
    input  logic                                active_i,
    input  logic [MATRIX_SIZE*2*DATA_WIDTH-1:0] result_flat_i,
    input  logic                                out_ready_i,
    output logic [2*DATA_WIDTH-1:0]             out_data_o,
    output logic                                out_valid_o,
    output logic                                out_last_o,
    output logic                                drain_done_o
);
    localparam int OCW = cw(MATRIX_SIZE);

    logic [MATRIX_SIZE-1:0][2*DATA_WIDTH-1:0] res_q;
    logic [OCW-1:0] ocnt_q, ocnt_d;
    logic           hs;

    assign hs           = active_i && out_ready_i;
    assign out_valid_o  = active_i;
    assign out_data_o   = res_q[ocnt_q];
    assign out_last_o   = active_i && (ocnt_q == OCW'(MATRIX_SIZE-1));
    assign drain_done_o = hs && out_last_o;

    always_comb begin
        ocnt_d = ocnt_q;
        if (clr_i || capture_i || drain_done_o) ocnt_d = '0;
        else if (hs)                            ocnt_d = ocnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            ocnt_q <= '0;
        end else begin
            ocnt_q <= ocnt_d;
            if (capture_i) res_q <= result_flat_i;
        end
    end
endmodule

// File: rtl/mmu_stream_driver.sv
// Sequencer that gathers weights and an input vector, issues a
// matrix-unit job, and streams the result vector back out.
module mmu_stream_driver
    import npu_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MATRIX_SIZE    = DEF_MATRIX_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_start,
    input  logic cmd_keep_weights,
    output logic busy,
    output logic done,
    output logic error,
    mmu_stream_driver_if.slave bus,
    output logic mmu_start,
    output logic [MATRIX_SIZE*DATA_WIDTH-1:0] mmu_input_flat,
    output logic mmu_input_valid,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mmu_weight_flat,
    output logic mmu_weight_valid,
    input  logic mmu_done,
    input  logic [MATRIX_SIZE*2*DATA_WIDTH-1:0] mmu_result_flat,
    input  logic mmu_result_valid
);
    localparam int WN  = MATRIX_SIZE * MATRIX_SIZE;
    localparam int WCW = cw(WN);
    localparam int XCW = cw(MATRIX_SIZE);
    localparam int TCW = cw(TIMEOUT_CYCLES);

    drv_state_e state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [XCW-1:0] xcnt_q, xcnt_d;
    logic [TCW-1:0] timer_q, timer_d;
    logic wl_q, wl_d;
    logic err_q, err_d;

    logic [WN-1:0][DATA_WIDTH-1:0]          wt_q;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] x_q;

    logic wt_hs, x_hs, start_acc, cap, drain_done;

    assign wt_hs     = (state_q == ST_LOAD_W) && bus.s_wt_valid;
    assign x_hs      = (state_q == ST_LOAD_X) && bus.s_in_valid;
    assign start_acc = (state_q == ST_IDLE) && cmd_start;
    assign cap       = (state_q == ST_WAIT) && mmu_done && mmu_result_valid;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        xcnt_d  = xcnt_q;
        timer_d = timer_q;
        wl_d    = wl_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    err_d  = 1'b0;
                    wcnt_d = '0;
                    xcnt_d = '0;
                    if (cmd_keep_weights && wl_q) begin
                        state_d = ST_LOAD_X;
                    end else begin
                        state_d = ST_LOAD_W;
                        wl_d    = 1'b0;
                    end
                end
            end
            ST_LOAD_W: begin
                if (bus.s_wt_valid) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == WCW'(WN-1)) begin
                        wl_d    = 1'b1;
                        state_d = ST_LOAD_X;
                    end
                end
            end
            ST_LOAD_X: begin
                if (bus.s_in_valid) begin
                    xcnt_d = xcnt_q + 1'b1;
                    if (xcnt_q == XCW'(MATRIX_SIZE-1)) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cap) begin
                    state_d = ST_DRAIN;
                end else if (timer_q == TCW'(TIMEOUT_CYCLES-1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            xcnt_q  <= '0;
            timer_q <= '0;
            wl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            xcnt_q  <= xcnt_d;
            timer_q <= timer_d;
            wl_q    <= wl_d;
            err_q   <= err_d;
        end
    end

    // Operand registers only change in the load states, so the flat
    // buses stay stable across ISSUE and WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt_q <= '0;
            x_q  <= '0;
        end else begin
            if (wt_hs) wt_q[wcnt_q] <= bus.s_wt_data;
            if (x_hs)  x_q[xcnt_q]  <= bus.s_in_data;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign error            = err_q;
    assign done             = drain_done;
    assign bus.s_wt_ready   = (state_q == ST_LOAD_W);
    assign bus.s_in_ready   = (state_q == ST_LOAD_X);
    assign mmu_start        = (state_q == ST_ISSUE);
    assign mmu_input_valid  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign mmu_weight_valid = mmu_input_valid;
    assign mmu_input_flat   = x_q;
    assign mmu_weight_flat  = wt_q;

    mmu_result_serializer #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MATRIX_SIZE (MATRIX_SIZE)
    ) u_ser (
        .clk           (clk),
        .rst_n         (rst_n),
        .clr_i         (start_acc),
        .capture_i     (cap),
        .active_i      (state_q == ST_DRAIN),
        .result_flat_i (mmu_result_flat),
        .out_ready_i   (bus.m_out_ready),
        .out_data_o    (bus.m_out_data),
        .out_valid_o   (bus.m_out_valid),
        .out_last_o    (bus.m_out_last),
        .drain_done_o  (drain_done)
    );
endmodule
